// File: rtl/key_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg
// Shared definitions for the key event arbiter:
//   - event type codes carried per key and in the event FIFO
//   - arbiter state encoding (SCAN / HOLD)
//   - packed event record {key, type} and its width
//   - trig_to_type(): collapses one key's {single, double, long} pulses into
//     a single type code, with long > double > single priority
// ---------------------------------------------------------------------------
package key_pkg;

    localparam int KEY_W  = 3;
    localparam int TYPE_W = 2;
    localparam int EVT_W  = KEY_W + TYPE_W;

    localparam logic [TYPE_W-1:0] TYPE_NONE   = 2'd0;
    localparam logic [TYPE_W-1:0] TYPE_SINGLE = 2'd1;
    localparam logic [TYPE_W-1:0] TYPE_DOUBLE = 2'd2;
    localparam logic [TYPE_W-1:0] TYPE_LONG   = 2'd3;

    localparam logic [0:0] ST_SCAN = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    typedef struct packed {
        logic [KEY_W-1:0]  key;
        logic [TYPE_W-1:0] etype;
    } key_evt_t;

    // trig = {single, double, long}, as emitted by the key function modules.
    function automatic logic [TYPE_W-1:0] trig_to_type(input logic [2:0] trig);
        if (trig[0])      return TYPE_LONG;
        else if (trig[1]) return TYPE_DOUBLE;
        else if (trig[2]) return TYPE_SINGLE;
        else              return TYPE_NONE;
    endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// ---------------------------------------------------------------------------
// key_evt_fifo
// Synchronous FIFO with registered count and registered full flag.
// A push is accepted only when the FIFO is not full at the start of the
// cycle; a pop in the same cycle does not make room for it.
//
// Parameters: DEPTH (power of two, >= 2), WIDTH (entry width)
// Ports:
//   CLOCK    in   clock
//   RESET    in   asynchronous reset, active low
//   push_i   in   write data_i (ignored when full)
//   pop_i    in   discard head entry (ignored when empty)
//   data_i   in   entry to write
//   data_o   out  head entry (meaningful only when not empty)
//   full_o   out  FIFO holds DEPTH entries (registered)
//   empty_o  out  FIFO holds no entries
// ---------------------------------------------------------------------------
module key_evt_fifo
    import key_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = EVT_W
)
(
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             do_push, do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && (count_q != '0);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_d    = do_push ? wr_q + 1'b1 : wr_q;
        rd_d    = do_pop  ? rd_q + 1'b1 : rd_q;
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        full_d  = (count_d == CNT_W'(DEPTH));
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    // NOTE: the storage array has no reset; an entry is only observed after
    // it has been written, and the count/pointers define what is valid.
    always_ff @(posedge CLOCK) begin
        if (do_push) mem[wr_q] <= data_i;
    end

    assign data_o  = mem[rd_q];
    assign full_o  = full_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/key_event_arbiter.sv
// ---------------------------------------------------------------------------
// key_event_arbiter
// Latches click events from NKEY key channels, grants them round-robin into
// an event FIFO and presents the FIFO head on a valid/ready port.
//
// Parameters: NKEY (2..8), DEPTH (FIFO depth, power of two, >= 2)
// Ports:
//   CLOCK   in   clock
//   RESET   in   asynchronous reset, active low
//   iTrig   in   per key k, bits [3k+2:3k] = {single, double, long} pulses
//   oValid  out  FIFO head valid
//   iReady  in   consumer takes the head when oValid && iReady
//   oKeyID  out  key index of head event (0 when not valid)
//   oType   out  head event type 1 single / 2 double / 3 long (0 when not valid)
//   oFull   out  FIFO holds DEPTH entries
//   oDrop   out  saturating count of overwritten pending events
//                (present only when KEY_ARB_DROP_CNT_EN is defined)
// ---------------------------------------------------------------------------
module key_event_arbiter
    import key_pkg::*;
#(
    parameter int NKEY  = 4,
    parameter int DEPTH = 8
)
(
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic [3*NKEY-1:0] iTrig,
    output logic              oValid,
    input  logic              iReady,
    output logic [KEY_W-1:0]  oKeyID,
    output logic [TYPE_W-1:0] oType,
`ifdef KEY_ARB_DROP_CNT_EN
    output logic [15:0]       oDrop,
`endif
    output logic              oFull
);

    logic [TYPE_W-1:0] pend_q [NKEY];
    logic [TYPE_W-1:0] pend_d [NKEY];
    logic [TYPE_W-1:0] new_type [NKEY];
    logic [KEY_W-1:0]  rr_q, rr_d;
    logic [0:0]        state_q, state_d;
    logic              any_pend;
    logic              grant;
    logic [KEY_W-1:0]  grant_idx;
    logic [TYPE_W-1:0] grant_type;
    logic              fifo_full, fifo_empty;
    key_evt_t          push_evt, head_evt;

    always_comb begin
        for (int k = 0; k < NKEY; k++) begin
            new_type[k] = trig_to_type(iTrig[3*k +: 3]);
        end
    end

    // Round-robin search starting at rr_q, plus the SCAN/HOLD control.
    always_comb begin : arbiter
        logic             found;
        logic [KEY_W:0]   idx;
        any_pend   = 1'b0;
        grant      = 1'b0;
        grant_idx  = '0;
        grant_type = TYPE_NONE;
        state_d    = state_q;
        found      = 1'b0;
        idx        = '0;
        for (int k = 0; k < NKEY; k++) begin
            any_pend = any_pend | (pend_q[k] != TYPE_NONE);
        end
        for (int i = 0; i < NKEY; i++) begin
            idx = (KEY_W+1)'(rr_q) + (KEY_W+1)'(i);
            if (idx >= (KEY_W+1)'(NKEY)) idx = idx - (KEY_W+1)'(NKEY);
            for (int k = 0; k < NKEY; k++) begin
                if (!found && idx == (KEY_W+1)'(k) && pend_q[k] != TYPE_NONE) begin
                    found      = 1'b1;
                    grant_idx  = KEY_W'(k);
                    grant_type = pend_q[k];
                end
            end
        end
        case (state_q)
            ST_SCAN: begin
                if (any_pend) begin
                    if (fifo_full) state_d = ST_HOLD;
                    else           grant   = 1'b1;
                end
            end
            ST_HOLD: begin
                // Leaving HOLD grants in the same cycle so no push slot is lost.
                if (!fifo_full) begin
                    state_d = ST_SCAN;
                    grant   = any_pend;
                end
            end
            default: state_d = ST_SCAN;
        endcase
    end

    // A pulse on the key being granted replaces the cleared slot rather than
    // being lost; a pulse on any other busy key overwrites (newest wins).
    always_comb begin
        for (int k = 0; k < NKEY; k++) begin
            if (grant && grant_idx == KEY_W'(k)) pend_d[k] = new_type[k];
            else if (new_type[k] != TYPE_NONE)  pend_d[k] = new_type[k];
            else                                pend_d[k] = pend_q[k];
        end
        if (!grant)                                rr_d = rr_q;
        else if (grant_idx == KEY_W'(NKEY - 1))    rr_d = '0;
        else                                       rr_d = grant_idx + 1'b1;
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_SCAN;
            rr_q    <= '0;
            for (int k = 0; k < NKEY; k++) pend_q[k] <= TYPE_NONE;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            for (int k = 0; k < NKEY; k++) pend_q[k] <= pend_d[k];
        end
    end

`ifdef KEY_ARB_DROP_CNT_EN
    logic [15:0]    drop_q, drop_d;
    logic [KEY_W:0] n_drop;
    logic [16:0]    drop_sum;

    always_comb begin
        n_drop = '0;
        for (int k = 0; k < NKEY; k++) begin
            if (new_type[k] != TYPE_NONE && pend_q[k] != TYPE_NONE &&
                !(grant && grant_idx == KEY_W'(k)))
                n_drop = n_drop + (KEY_W+1)'(1);
        end
        drop_sum = {1'b0, drop_q} + 17'(n_drop);
        drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) drop_q <= '0;
        else        drop_q <= drop_d;
    end

    assign oDrop = drop_q;
`endif

    assign push_evt = '{key: grant_idx, etype: grant_type};

    key_evt_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
        .push_i  (grant),
        .pop_i   (oValid && iReady),
        .data_i  (push_evt),
        .data_o  (head_evt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Head is masked while empty so the unreset storage never reaches the port.
    assign oValid = !fifo_empty;
    assign oKeyID = oValid ? head_evt.key   : '0;
    assign oType  = oValid ? head_evt.etype : '0;
    assign oFull  = fifo_full;

endmodule

// File: tb/tb_key_event_arbiter.sv
// ---------------------------------------------------------------------------
// tb_key_event_arbiter
// Directed bench for key_event_arbiter (NKEY=4, DEPTH=8). Outputs are sampled
// 1 time unit after the rising edge; inputs are driven at the same point.
// Drop counter checks are active when KEY_ARB_DROP_CNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_key_event_arbiter;
    import key_pkg::*;

    localparam int NKEY  = 4;
    localparam int DEPTH = 8;

    logic              CLOCK;
    logic              RESET;
    logic [3*NKEY-1:0] iTrig;
    logic              oValid;
    logic              iReady;
    logic [2:0]        oKeyID;
    logic [1:0]        oType;
    logic              oFull;
`ifdef KEY_ARB_DROP_CNT_EN
    logic [15:0]       oDrop;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    key_event_arbiter #(.NKEY(NKEY), .DEPTH(DEPTH)) dut (
        .CLOCK  (CLOCK),
        .RESET  (RESET),
        .iTrig  (iTrig),
        .oValid (oValid),
        .iReady (iReady),
        .oKeyID (oKeyID),
        .oType  (oType),
`ifdef KEY_ARB_DROP_CNT_EN
        .oDrop  (oDrop),
`endif
        .oFull  (oFull)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    function automatic logic [2:0] trig_bits(input int t);
        case (t)
            1:       return 3'b100;
            2:       return 3'b010;
            3:       return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    // Event i goes to key i%4 with type (i%3)+1, one pulse per cycle.
    task automatic fill(input int n);
        for (int i = 0; i < n; i++) begin
            iTrig = '0;
            iTrig[3*(i%4) +: 3] = trig_bits((i % 3) + 1);
            tick();
        end
        iTrig = '0;
    endtask

    task automatic drain(input int budget, output int got,
                         output logic [2:0] last_key, output logic [1:0] last_type);
        got = 0; last_key = '0; last_type = '0;
        iReady = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (oValid) begin
                got++;
                last_key  = oKeyID;
                last_type = oType;
            end
            tick();
        end
        iReady = 1'b0;
    endtask

    initial begin
        int         got;
        logic [2:0] lk;
        logic [1:0] lt;

        RESET = 1'b0; iTrig = '0; iReady = 1'b0;
        tick(); tick();
        check("rst_valid", 32'(oValid), 0);
        check("rst_key",   32'(oKeyID), 0);
        check("rst_type",  32'(oType),  0);
        check("rst_full",  32'(oFull),  0);
`ifdef KEY_ARB_DROP_CNT_EN
        check("rst_drop",  32'(oDrop),  0);
`endif
        RESET = 1'b1;
        tick();

        // Single long pulse on key 2: oValid two edges later.
        iTrig[3*2 +: 3] = 3'b001;
        tick();
        iTrig = '0;
        check("t1_pend2", 32'(dut.pend_q[2]), 3);
        check("t1_valid_early", 32'(oValid), 0);
        tick();
        check("t1_valid", 32'(oValid), 1);
        check("t1_key",   32'(oKeyID), 2);
        check("t1_type",  32'(oType),  3);
        iReady = 1'b1;
        tick();
        iReady = 1'b0;
        check("t1_popped", 32'(oValid), 0);
        check("t1_rr", 32'(dut.rr_q), 3);

        // Bring rrPtr back to 0 via key 3.
        iTrig[3*3 +: 3] = 3'b100;
        tick();
        iTrig = '0;
        tick();
        check("t2a_key",  32'(oKeyID), 3);
        check("t2a_type", 32'(oType),  1);
        iReady = 1'b1;
        tick();
        iReady = 1'b0;
        check("t2a_rr", 32'(dut.rr_q), 0);
        check("t2a_empty", 32'(oValid), 0);

        // Four simultaneous singles, consumer stalled.
        iTrig = 12'b100_100_100_100;
        tick();
        iTrig = '0;
        tick();
        tick();
        check("t2_rr_after_k1", 32'(dut.rr_q), 2);
        check("t2_cnt2", 32'(dut.u_fifo.count_q), 2);
        tick();
        tick();
        check("t2_cnt4", 32'(dut.u_fifo.count_q), 4);
        check("t2_rr_wrap", 32'(dut.rr_q), 0);
        iReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t2_valid", 32'(oValid), 1);
            check("t2_key",   32'(oKeyID), 32'(i));
            check("t2_type",  32'(oType),  1);
            tick();
        end
        iReady = 1'b0;
        check("t2_drained", 32'(oValid), 0);

        // Ten events into an eight-deep FIFO: two stay pending in HOLD.
        fill(10);
        tick();
        check("t3_full",  32'(oFull), 1);
        check("t3_state", 32'(dut.state_q), 32'(ST_HOLD));
        check("t3_pend0", 32'(dut.pend_q[0]), 3);
        check("t3_pend1", 32'(dut.pend_q[1]), 1);
        got = 0;
        iReady = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (oValid && got < 10) begin
                check("t3_key",  32'(oKeyID), 32'(got % 4));
                check("t3_type", 32'(oType),  32'((got % 3) + 1));
                got++;
            end
            tick();
        end
        iReady = 1'b0;
        check("t3_delivered", 32'(got), 10);
        check("t3_empty", 32'(oValid), 0);
`ifdef KEY_ARB_DROP_CNT_EN
        check("t3_nodrop", 32'(oDrop), 0);
`endif

        // Full FIFO with one pending: pop now, push next cycle (8 -> 7 -> 8).
        fill(9);
        tick();
        check("t5_cnt8", 32'(dut.u_fifo.count_q), 8);
        check("t5_hold", 32'(dut.state_q), 32'(ST_HOLD));
        check("t5_head_key", 32'(oKeyID), 0);
        iReady = 1'b1;
        tick();
        iReady = 1'b0;
        check("t5_cnt7", 32'(dut.u_fifo.count_q), 7);
        check("t5_notfull", 32'(oFull), 0);
        tick();
        check("t5_cnt8b", 32'(dut.u_fifo.count_q), 8);
        check("t5_full", 32'(oFull), 1);
        check("t5_scan", 32'(dut.state_q), 32'(ST_SCAN));
        drain(30, got, lk, lt);
        check("t5_delivered", 32'(got), 8);

        // Overwrite during HOLD: key 1 single then double -> double delivered.
        fill(8);
        tick();
        check("t4_full", 32'(oFull), 1);
        iTrig[3*1 +: 3] = 3'b100;
        tick();
        iTrig = '0;
        iTrig[3*1 +: 3] = 3'b010;
        tick();
        iTrig = '0;
        check("t4_hold",  32'(dut.state_q), 32'(ST_HOLD));
        check("t4_pend1", 32'(dut.pend_q[1]), 2);
`ifdef KEY_ARB_DROP_CNT_EN
        check("t4_drop", 32'(oDrop), 1);
`endif
        drain(30, got, lk, lt);
        check("t4_delivered", 32'(got), 9);
        check("t4_last_key",  32'(lk), 1);
        check("t4_last_type", 32'(lt), 2);

        // Reset mid-operation with queued and pending events.
        fill(6);
        check("t6_cnt5",  32'(dut.u_fifo.count_q), 5);
        check("t6_pend1", 32'(dut.pend_q[1]), 3);
        RESET = 1'b0;
        #1;
        check("t6_valid", 32'(oValid), 0);
        check("t6_cnt0",  32'(dut.u_fifo.count_q), 0);
        check("t6_pend_clr", 32'(dut.pend_q[1]), 0);
        check("t6_key",   32'(oKeyID), 0);
`ifdef KEY_ARB_DROP_CNT_EN
        check("t6_drop", 32'(oDrop), 0);
`endif
        tick();
        tick();
        RESET = 1'b1;
        tick();
        iTrig[3*3 +: 3] = 3'b010;
        tick();
        iTrig = '0;
        check("t6_post_early", 32'(oValid), 0);
        tick();
        check("t6_post_valid", 32'(oValid), 1);
        check("t6_post_key",   32'(oKeyID), 3);
        check("t6_post_type",  32'(oType),  2);
        iReady = 1'b1;
        tick();
        iReady = 1'b0;
        check("t6_post_pop", 32'(oValid), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
